// File: rtl/bit_population_generator.sv
// Streams every WIDTH-bit word whose popcount equals the requested K, in increasing order.
// Optional `BIT_POP_GEN_IDX_EN adds idx_o, the 0-based index of the current word within the request.
module bit_population_generator #(
    parameter int WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [$clog2(WIDTH):0] cnt_i,
    input  logic                   cnt_val_i,
    output logic                   cnt_rdy_o,
    output logic [WIDTH-1:0]       data_o,
    output logic                   data_val_o,
    input  logic                   data_rdy_i,
    output logic                   data_last_o
`ifdef BIT_POP_GEN_IDX_EN
    ,
    output logic [WIDTH-1:0]       idx_o
`endif
);
    localparam int KW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ONES = '1;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_p1, state_nxt;

    logic [WIDTH-1:0] word_p1;
    logic [WIDTH-1:0] last_pat_p1;
    logic [KW-1:0]    k_sat;
    logic [WIDTH-1:0] first_w;
    logic [WIDTH-1:0] last_w;
    logic [WIDTH:0]   step_w;
    logic             accept;
    logic             xfer;
    logic             at_last;

    function automatic logic [KW-1:0] sat_k(input logic [KW-1:0] k);
        if (k > KW'(WIDTH))
            return KW'(WIDTH);
        return k;
    endfunction

    // Gosper successor; the (WIDTH+1)-bit result keeps the carry out of x + c visible.
    function automatic logic [WIDTH:0] gosper_step(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] xe;
        logic [WIDTH:0] c;
        logic [WIDTH:0] r;
        logic [WIDTH:0] t;
        int             tz;
        xe = {1'b0, x};
        c  = xe & (-xe);
        r  = xe + c;
        tz = 0;
        for (int i = WIDTH; i >= 0; i--)
            if (c[i])
                tz = i;
        t = ((r ^ xe) >> 2) >> tz;
        return r | t;
    endfunction

    assign k_sat   = sat_k(cnt_i);
    assign first_w = ~(ONES << k_sat);
    assign last_w  = ~(ONES >> k_sat);
    assign step_w  = gosper_step(word_p1);
    assign at_last = (word_p1 == last_pat_p1);
    assign data_o  = word_p1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_p1 <= IDLE;
        else
            state_p1 <= state_nxt;
    end

    always_comb begin
        state_nxt   = state_p1;
        cnt_rdy_o   = 1'b0;
        data_val_o  = 1'b0;
        data_last_o = 1'b0;
        accept      = 1'b0;
        xfer        = 1'b0;
        case (state_p1)
            IDLE: begin
                cnt_rdy_o = 1'b1;
                accept    = cnt_val_i;
                if (cnt_val_i)
                    state_nxt = RUN;
            end
            RUN: begin
                data_val_o  = 1'b1;
                data_last_o = at_last;
                xfer        = data_rdy_i;
                if (data_rdy_i && at_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: current word and the terminal pattern latched at accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_p1     <= '0;
            last_pat_p1 <= '0;
        end else if (accept) begin
            word_p1     <= first_w;
            last_pat_p1 <= last_w;
        end else if (xfer && !at_last && !step_w[WIDTH]) begin
            word_p1 <= step_w[WIDTH-1:0];
        end
    end

`ifdef BIT_POP_GEN_IDX_EN
    logic [WIDTH-1:0] idx_p1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            idx_p1 <= '0;
        else if (accept)
            idx_p1 <= '0;
        else if (xfer && !at_last)
            idx_p1 <= idx_p1 + WIDTH'(1);
    end

    assign idx_o = idx_p1;
`endif

endmodule

// File: tb/tb_bit_population_generator.sv
// Self-checking bench: a WIDTH=4 and a WIDTH=16 instance compared every cycle against an
// enumerate-and-filter model of the word stream, plus hand-computed literal expectations.
module tb_bit_population_generator;
    typedef logic [15:0] wq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  cnt[2];
    logic        cval[2];
    logic        drdy[2];

    logic        a_crdy, a_dval, a_last;
    logic [3:0]  a_data;
    logic        b_crdy, b_dval, b_last;
    logic [15:0] b_data;
`ifdef BIT_POP_GEN_IDX_EN
    logic [3:0]  a_idx;
    logic [15:0] b_idx;
    logic [15:0] m_idx[2];
    assign m_idx[0] = {12'b0, a_idx};
    assign m_idx[1] = b_idx;
`endif

    logic [15:0] m_data[2];
    logic        m_dval[2], m_last[2], m_crdy[2];
    assign m_data[0] = {12'b0, a_data};
    assign m_data[1] = b_data;
    assign m_dval[0] = a_dval;
    assign m_dval[1] = b_dval;
    assign m_last[0] = a_last;
    assign m_last[1] = b_last;
    assign m_crdy[0] = a_crdy;
    assign m_crdy[1] = b_crdy;

    bit_population_generator #(.WIDTH(4)) u_w4 (
        .clk_i      (clk),
        .rst_i      (rst),
        .cnt_i      (cnt[0][2:0]),
        .cnt_val_i  (cval[0]),
        .cnt_rdy_o  (a_crdy),
        .data_o     (a_data),
        .data_val_o (a_dval),
        .data_rdy_i (drdy[0]),
        .data_last_o(a_last)
`ifdef BIT_POP_GEN_IDX_EN
        ,
        .idx_o      (a_idx)
`endif
    );

    bit_population_generator #(.WIDTH(16)) u_w16 (
        .clk_i      (clk),
        .rst_i      (rst),
        .cnt_i      (cnt[1]),
        .cnt_val_i  (cval[1]),
        .cnt_rdy_o  (b_crdy),
        .data_o     (b_data),
        .data_val_o (b_dval),
        .data_rdy_i (drdy[1]),
        .data_last_o(b_last)
`ifdef BIT_POP_GEN_IDX_EN
        ,
        .idx_o      (b_idx)
`endif
    );

    int   errors = 0;
    int   checks = 0;
    wq_t  expq[2];
    int   xcnt[2];
    int   kcur[2];
    logic [15:0] prevw[2];

    function automatic int width_of(input int i);
        return (i == 0) ? 4 : 16;
    endfunction

    // Every w-bit value with exactly min(kin, w) ones, ascending.
    function automatic wq_t enum_words(input int w, input int kin);
        wq_t q;
        int  k;
        k = (kin > w) ? w : kin;
        for (int v = 0; v < (1 << w); v++)
            if ($countones(v) == k)
                q.push_back(16'(v));
        return q;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rst_val%0d", i), 32'(m_dval[i]), 32'd0);
                chk($sformatf("rst_rdy%0d", i), 32'(m_crdy[i]), 32'd1);
                chk($sformatf("rst_last%0d", i), 32'(m_last[i]), 32'd0);
                chk($sformatf("rst_data%0d", i), 32'(m_data[i]), 32'd0);
                expq[i].delete();
                xcnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rdy%0d", i), 32'(m_crdy[i]), 32'(expq[i].size() == 0));
                chk($sformatf("val%0d", i), 32'(m_dval[i]), 32'(expq[i].size() != 0));
                if (expq[i].size() != 0) begin
                    chk($sformatf("data%0d", i), 32'(m_data[i]), 32'(expq[i][0]));
                    chk($sformatf("last%0d", i), 32'(m_last[i]), 32'(expq[i].size() == 1));
                    chk($sformatf("pop%0d", i), 32'($countones(m_data[i])), 32'(kcur[i]));
`ifdef BIT_POP_GEN_IDX_EN
                    chk($sformatf("idx%0d", i), 32'(m_idx[i]), 32'(xcnt[i]));
`endif
                    if (drdy[i]) begin
                        if (xcnt[i] > 0)
                            chk($sformatf("incr%0d", i), 32'(m_data[i] > prevw[i]), 32'd1);
                        prevw[i] = m_data[i];
                        void'(expq[i].pop_front());
                        xcnt[i]++;
                    end
                end else begin
                    chk($sformatf("last_idle%0d", i), 32'(m_last[i]), 32'd0);
                    if (cval[i]) begin
                        wq_t tq;
                        int  kin;
                        kin     = (i == 0) ? int'(cnt[0][2:0]) : int'(cnt[1]);
                        kcur[i] = (kin > width_of(i)) ? width_of(i) : kin;
                        tq      = enum_words(width_of(i), kin);
                        foreach (tq[j]) expq[i].push_back(tq[j]);
                        xcnt[i] = 0;
                    end
                end
            end
        end
    end

    task automatic request(input int i, input int k);
        cnt[i]  = 5'(k);
        cval[i] = 1'b1;
        @(posedge clk);
        #1;
        cval[i] = 1'b0;
    endtask

    task automatic run_idle(input int i, input int pct, input int budget);
        int n;
        n = 0;
        while (expq[i].size() != 0 && n < budget) begin
            drdy[i] = ($urandom_range(0, 99) < pct);
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("timeout%0d", i), 32'(expq[i].size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        wq_t        q;
        logic [3:0] lit[6];
        int         n;
        int         k;
        lit = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC};
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cnt[i] = '0; cval[i] = 1'b0; drdy[i] = 1'b0;
            xcnt[i] = 0; kcur[i] = 0; prevw[i] = '0;
        end

        q = enum_words(4, 2);
        chk("model_k2_size", 32'(q.size()), 32'd6);
        for (int j = 0; j < 6; j++)
            chk($sformatf("model_k2_w%0d", j), 32'(q[j]), 32'(lit[j]));
        q = enum_words(4, 0);
        chk("model_k0", 32'({q.size(), q[0]}), 32'h0001_0000);
        q = enum_words(4, 5);
        chk("model_k5", 32'({q.size(), q[0]}), 32'h0001_000F);
        q = enum_words(16, 8);
        chk("model_k8_size", 32'(q.size()), 32'd12870);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // WIDTH=4, K=2, consumer always ready: literal word sequence and timing.
        drdy[0] = 1'b1;
        request(0, 2);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("lit_k2_data%0d", j), 32'(a_data), 32'(lit[j]));
            chk($sformatf("lit_k2_last%0d", j), 32'(a_last), 32'(j == 5));
            chk($sformatf("lit_k2_busy%0d", j), 32'(a_crdy), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("lit_k2_rdy_t7", 32'(a_crdy), 32'd1);
        chk("lit_k2_val_t7", 32'(a_dval), 32'd0);

        // Boundary K values on WIDTH=4.
        request(0, 0);
        chk("lit_k0", 32'({a_dval, a_last, a_data}), 32'h30);
        run_idle(0, 60, 100);
        drdy[0] = 1'b0;
        request(0, 4);
        chk("lit_k4", 32'({a_dval, a_last, a_data}), 32'h3F);
        run_idle(0, 60, 100);
        drdy[0] = 1'b0;
        request(0, 5);
        chk("lit_k5", 32'({a_dval, a_last, a_data}), 32'h3F);
        run_idle(0, 60, 100);

        // Request valid held high through RUN: the next accept waits for the last transfer.
        cnt[0]  = 5'd3;
        cval[0] = 1'b1;
        repeat (30) begin
            drdy[0] = ($urandom_range(0, 99) < 50);
            @(posedge clk);
            #1;
        end
        cval[0] = 1'b0;
        run_idle(0, 60, 100);

        // WIDTH=16, K=8 under random backpressure.
        request(1, 8);
        run_idle(1, 75, 60000);
        chk("k8_transfers", 32'(xcnt[1]), 32'd12870);

        // Reset mid-stream after 10 words, then restart.
        drdy[1] = 1'b1;
        request(1, 3);
        n = 0;
        while (xcnt[1] < 10 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_after10", 32'(xcnt[1]), 32'd10);
        rst = 1'b1;
        #1;
        chk("rst_abort_val", 32'(b_dval), 32'd0);
        chk("rst_abort_rdy", 32'(b_crdy), 32'd1);
        chk("rst_abort_last", 32'(b_last), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        request(1, 3);
        chk("rst_restart", 32'(b_data), 32'h0007);
        run_idle(1, 70, 2000);

        // Random mix, including K above WIDTH on both instances.
        for (int r = 0; r < 6; r++) begin
            request(0, $urandom_range(0, 7));
            run_idle(0, 60, 200);
            k = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(13, 31);
            request(1, k);
            run_idle(1, 60, 4000);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
